// File: rtl/mod_counter.sv
// Up/down modulo counter over 0..MAX with wrap or saturate at the boundary, clear/load/enable.
// Latency: count, wrap and sat register 1 cycle after the request; no backpressure (sampled every edge).
module mod_counter #(
    parameter int unsigned       WIDTH    = 4,
    parameter longint unsigned   MAX      = 15,
    parameter bit                SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             sat
);

    localparam longint unsigned LIMIT = (64'd1 << WIDTH) - 64'd1;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_counter: WIDTH must be within 1..32");
    end
    if (MAX < 1 || MAX > LIMIT) begin : g_bad_max
        $error("mod_counter: MAX must be within 1..2^WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_sat;

    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_top;
    logic             w_bot;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_nxt_count;
    logic             w_nxt_wrap;
    logic             w_nxt_sat;

    // One extra bit keeps the step free of modulo-2^WIDTH aliasing.
    assign w_inc = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec = {1'b0, r_count} - {{WIDTH{1'b0}}, 1'b1};
    assign w_top = (r_count == MAX_V);
    assign w_bot = (r_count == '0);
    assign w_load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    always_comb begin
        w_nxt_count = r_count;
        w_nxt_wrap  = 1'b0;
        w_nxt_sat   = 1'b0;
        if (clear) begin
            w_nxt_count = '0;
        end else if (load) begin
            w_nxt_count = w_load_clamped;
        end else if (en) begin
            if (up) begin
                if (!w_top) begin
                    w_nxt_count = w_inc[WIDTH-1:0];
                end else if (SATURATE) begin
                    w_nxt_sat   = 1'b1;
                end else begin
                    w_nxt_count = '0;
                    w_nxt_wrap  = 1'b1;
                end
            end else begin
                if (!w_bot) begin
                    w_nxt_count = w_dec[WIDTH-1:0];
                end else if (SATURATE) begin
                    w_nxt_sat   = 1'b1;
                end else begin
                    w_nxt_count = MAX_V;
                    w_nxt_wrap  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_nxt_count;
            r_wrap  <= w_nxt_wrap;
            r_sat   <= w_nxt_sat;
        end
    end

    assign count  = r_count;
    assign at_max = w_top;
    assign at_min = w_bot;
    assign wrap   = r_wrap;
    assign sat    = r_sat;

`ifdef FORMAL
    // Properties only hold once a reset has been seen; the harness asserts rst in the first cycle.
    logic r_f_valid;
    always_ff @(posedge clk) begin
        if (rst) r_f_valid <= 1'b1;
    end

    a_le_max: assert property (@(posedge clk) r_f_valid |-> (r_count <= MAX_V));
    a_excl:   assert property (@(posedge clk) r_f_valid |-> !(r_wrap && r_sat));
    a_nowrap: assert property (@(posedge clk) r_f_valid && SATURATE |-> !r_wrap);
    a_nosat:  assert property (@(posedge clk) r_f_valid && !SATURATE |-> !r_sat);

    a_inc: assert property (@(posedge clk) disable iff (rst)
        r_f_valid && !clear && !load && en && up && !w_top |=> r_count == $past(r_count) + 1'b1);
    a_dec: assert property (@(posedge clk) disable iff (rst)
        r_f_valid && !clear && !load && en && !up && !w_bot |=> r_count == $past(r_count) - 1'b1);
    a_top: assert property (@(posedge clk) disable iff (rst)
        r_f_valid && !clear && !load && en && up && w_top
        |=> (SATURATE ? (r_count == MAX_V && r_sat) : (r_count == '0 && r_wrap)));
    a_bot: assert property (@(posedge clk) disable iff (rst)
        r_f_valid && !clear && !load && en && !up && w_bot
        |=> (SATURATE ? (r_count == '0 && r_sat) : (r_count == MAX_V && r_wrap)));
    a_load: assert property (@(posedge clk) disable iff (rst)
        r_f_valid && !clear && load |=> r_count == $past(w_load_clamped));
    a_wrap_src: assert property (@(posedge clk) disable iff (rst)
        r_f_valid && $past(r_f_valid) && r_wrap |-> $past(en && (up ? w_top : w_bot)));
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter over five parameter sets; stimulus queues expectations, a negedge monitor checks them.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst, clear, load, en, up;
    logic [7:0] load_val;

    always #5 clk = ~clk;

    logic [3:0] c0, c1, c2;
    logic [7:0] c3;
    logic [0:0] c4;
    logic [4:0] amx, amn, wr, st;

    mod_counter #(.WIDTH(4), .MAX(15),  .SATURATE(1'b0)) d0 (.clk(clk), .rst(rst), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .en(en), .up(up), .count(c0), .at_max(amx[0]), .at_min(amn[0]), .wrap(wr[0]), .sat(st[0]));
    mod_counter #(.WIDTH(4), .MAX(9),   .SATURATE(1'b0)) d1 (.clk(clk), .rst(rst), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .en(en), .up(up), .count(c1), .at_max(amx[1]), .at_min(amn[1]), .wrap(wr[1]), .sat(st[1]));
    mod_counter #(.WIDTH(4), .MAX(9),   .SATURATE(1'b1)) d2 (.clk(clk), .rst(rst), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .en(en), .up(up), .count(c2), .at_max(amx[2]), .at_min(amn[2]), .wrap(wr[2]), .sat(st[2]));
    mod_counter #(.WIDTH(8), .MAX(200), .SATURATE(1'b0)) d3 (.clk(clk), .rst(rst), .clear(clear), .load(load),
        .load_val(load_val), .en(en), .up(up), .count(c3), .at_max(amx[3]), .at_min(amn[3]), .wrap(wr[3]), .sat(st[3]));
    mod_counter #(.WIDTH(1), .MAX(1),   .SATURATE(1'b0)) d4 (.clk(clk), .rst(rst), .clear(clear), .load(load),
        .load_val(load_val[0:0]), .en(en), .up(up), .count(c4), .at_max(amx[4]), .at_min(amn[4]), .wrap(wr[4]), .sat(st[4]));

    typedef struct {
        int id;
        int cyc;
        int cnt;
        bit w, s, mx, mn;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   maxv[5] = '{15, 9, 9, 200, 1};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int   a_cnt;
            e = q.pop_front();
            case (e.id)
                0:       a_cnt = int'(c0);
                1:       a_cnt = int'(c1);
                2:       a_cnt = int'(c2);
                3:       a_cnt = int'(c3);
                default: a_cnt = int'(c4);
            endcase
            tests++;
            if (e.cyc != cyc || a_cnt != e.cnt || wr[e.id] != e.w || st[e.id] != e.s ||
                amx[e.id] != e.mx || amn[e.id] != e.mn) begin
                fails++;
                $display("FAIL dut%0d cyc%0d: got count=%0d wrap=%0b sat=%0b at_max=%0b at_min=%0b, expected count=%0d wrap=%0b sat=%0b at_max=%0b at_min=%0b (due cyc%0d)",
                         e.id, cyc, a_cnt, wr[e.id], st[e.id], amx[e.id], amn[e.id],
                         e.cnt, e.w, e.s, e.mx, e.mn, e.cyc);
            end
        end
    end

    task automatic step(input int id, input bit r, c, l, e, u, input int lv,
                        input int ec, input bit ew, input bit es);
        exp_t x;
        rst = r; clear = c; load = l; en = e; up = u; load_val = 8'(lv);
        x.id = id; x.cyc = cyc + 1; x.cnt = ec; x.w = ew; x.s = es;
        x.mx = (ec == maxv[id]); x.mn = (ec == 0);
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; load_val = 8'd0;
        @(posedge clk);
        #2;

        // W4/M15 wrap: 0..15 then 0 with wrap, then 1
        step(0, 1,0,0,0,0, 0,  0, 0, 0);
        for (int k = 1; k <= 17; k++)
            step(0, 0,0,0,1,1, 0,  k % 16, (k == 16), 0);

        // W4/M9 wrap, counting down from reset
        step(1, 1,0,0,0,0, 0,  0, 0, 0);
        step(1, 0,0,0,1,0, 0,  9, 1, 0);
        for (int k = 2; k <= 10; k++)
            step(1, 0,0,0,1,0, 0,  10 - k, 0, 0);
        step(1, 0,0,0,1,0, 0,  9, 1, 0);

        // W4/M9 saturate: clamped load, sat held, release, then bottom saturation
        step(2, 1,0,0,0,0, 0,  0, 0, 0);
        step(2, 0,0,1,0,0, 12, 9, 0, 0);
        for (int k = 0; k < 3; k++)
            step(2, 0,0,0,1,1, 0,  9, 0, 1);
        step(2, 0,0,0,1,0, 0,  8, 0, 0);
        step(2, 0,0,1,0,0, 0,  0, 0, 0);
        step(2, 0,0,0,1,0, 0,  0, 0, 1);
        step(2, 0,0,0,0,0, 0,  0, 0, 0);

        // Priority on W4/M9 starting from 5
        step(1, 1,0,0,0,0, 0,  0, 0, 0);
        step(1, 0,0,1,0,0, 5,  5, 0, 0);
        step(1, 1,1,1,1,1, 3,  0, 0, 0);
        step(1, 0,0,1,0,0, 5,  5, 0, 0);
        step(1, 0,1,1,0,0, 3,  0, 0, 0);
        step(1, 0,0,1,1,1, 3,  3, 0, 0);
        step(1, 0,0,0,0,1, 0,  3, 0, 0);
        step(1, 0,0,1,0,0, 15, 9, 0, 0);

        // W8/M200: reset mid-count with en high, resume, clamp and wrap at 200
        step(3, 1,0,0,0,0, 0,   0, 0, 0);
        step(3, 0,0,1,0,0, 149, 149, 0, 0);
        step(3, 0,0,0,1,1, 0,   150, 0, 0);
        step(3, 1,0,0,1,1, 0,   0, 0, 0);
        step(3, 0,0,0,1,1, 0,   1, 0, 0);
        step(3, 0,0,1,0,0, 255, 200, 0, 0);
        step(3, 0,0,0,1,1, 0,   0, 1, 0);
        step(3, 0,0,0,1,0, 0,   200, 1, 0);
        step(3, 0,0,0,1,0, 0,   199, 0, 0);

        // W1/M1: alternating direction so every step crosses the boundary
        step(4, 1,0,0,0,0, 0,  0, 0, 0);
        for (int k = 0; k < 8; k++)
            step(4, 0,0,0,1,(k % 2 == 1), 0,  (k % 2 == 0) ? 1 : 0, 1, 0);

        rst = 1'b0; en = 1'b0; load = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo counter, the general-purpose successor to the fixed 4-bit up-counter. It counts in either direction over the full range 0..MAX and supports synchronous clear, parallel load and an enable. At the range boundary it either wraps or saturates, selected by parameter, and it reports boundary events through registered pulses. It is used wherever a formally checked event, timeout or index counter is needed, and it carries its own formal properties under `FORMAL`.

## Interface
Parameters:
- WIDTH, 4: counter width in bits; legal range 1..32.
- MAX, 15: terminal value. Legal range 1..2^WIDTH-1; out-of-range values are rejected at elaboration.
- SATURATE, 0: boundary mode. 0 = wrap, 1 = hold at the boundary.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- clear  input  1  synchronous clear to 0.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- count  output  WIDTH  current count (registered).
- at_max  output  1  combinational: count == MAX.
- at_min  output  1  combinational: count == 0.
- wrap  output  1  registered one-cycle pulse after a wrap step.
- sat  output  1  registered one-cycle pulse after a step blocked at a boundary.

## Operation
- Priority per edge is rst > clear > load > en. Lower-priority requests in the same cycle are ignored.
- rst: count←0, wrap←0, sat←0.
- clear: count←0, wrap←0, sat←0.
- load: count←min(load_val, MAX). Values above MAX are clamped to MAX, not truncated. wrap←0, sat←0.
- en=1, up=1:
  - count<MAX: count←count+1.
  - count==MAX, SATURATE=0: count←0, wrap←1.
  - count==MAX, SATURATE=1: count holds at MAX, sat←1.
- en=1, up=0:
  - count>0: count←count−1.
  - count==0, SATURATE=0: count←MAX, wrap←1.
  - count==0, SATURATE=1: count holds at 0, sat←1.
- en=0 with no higher-priority request: count holds; wrap←0, sat←0.
- Invariants:
  - count never exceeds MAX.
  - wrap and sat are never high in the same cycle.
  - wrap is never 1 when SATURATE=1.
  - sat is never 1 when SATURATE=0.
- Arithmetic is performed in WIDTH+1 bits so there is no silent modulo-2^WIDTH overflow. MAX=2^WIDTH-1 behaves identically to the natural wrap.
- Direction may change on any cycle. There is no turnaround penalty.
- Formal properties (under `FORMAL`, with reset assumed high in the initial cycle):
  - count ≤ MAX.
  - Each enabled step changes count by exactly ±1 or takes the boundary action defined above.
  - A load reflects the clamped value on the next cycle.
  - A pulse on wrap implies the previous count was at the boundary for the previous direction.

## Timing
- Single state stage. count, wrap and sat update on the same edge as the request that causes them, so results are visible 1 cycle after the request.
- at_max and at_min follow count combinationally, in the same cycle.
- wrap and sat each last exactly 1 cycle per boundary event. Back-to-back boundary events produce consecutive pulses:
  - with MAX=1, continuous up-counting in wrap mode wraps every 2 cycles;
  - in saturate mode, en held at the boundary gives sat high every cycle.
- Reset asserted mid-count takes effect on the next edge regardless of en, load or clear. All outputs read 0 in the following cycle, except at_min, which reads 1.
- There are no handshakes. Inputs are sampled every edge and have no hold requirement beyond one cycle.

## Test plan
- WIDTH=4, MAX=15, SATURATE=0: rst, then en=1, up=1 for 17 cycles → count runs 0..15, then 0. wrap is high only in the cycle count reads 0 after 15. at_max is high while count=15.
- WIDTH=4, MAX=9, SATURATE=0: en=1, up=0 from reset → count reads 9 with wrap=1, then 8, 7, and so on. count never reaches 10..15.
- WIDTH=4, MAX=9, SATURATE=1: load with load_val=12 → count=9. Then en=1, up=1 for 3 cycles → count stays 9 and sat is high all 3 cycles. Then up=0 → count=8, sat=0.
- Priority, with count=5: assert rst, clear, load (load_val=3) and en together → count=0. Then clear+load → 0. Then load+en (load_val=3) → 3.
- Reset mid-operation, WIDTH=8, MAX=200: count up to 150, assert rst for 1 cycle with en=1 → count=0, wrap=0, sat=0, at_min=1. Counting resumes from 1 on the next enabled cycle.
- WIDTH=1, MAX=1, SATURATE=0: en=1, toggle up every cycle → count alternates and every step is a boundary step, so wrap is high every cycle. Formal run (depth ≥ 20) proves all properties for each parameter set above.
